conv_quad_worker: RTL and testbench

- Slave-side responder to the quadrant enable / sp_en / fin handshake driven by the sequencing controller.
- When enabled, it computes one quadrant of a 3x3 valid convolution with ReLU over an image held in input SRAM, using a kernel held in weight SRAM.
- It pulses sp_en once per output pixel, writes that pixel during the controller's two disabled cycles, and pulses fin after the last output.
- Four instances (one per quadrant) share the SRAMs through the top-level mux.

---
 rtl/conv_quad_worker.sv | 219 +++++++++++++++++++++
 tb/tb_conv_quad_worker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_quad_worker.sv
// rtl/conv_quad_worker.sv - one quadrant of a 3x3 valid convolution with ReLU/saturation
// Responds to the controller's en / sp_en / fin handshake; SRAMs are shared through the top-level mux.
module conv_quad_worker #(
  parameter int IMG_DIM  = 8,
  parameter int Q_DIM    = 3,
  parameter int ROW_BASE = 0,
  parameter int COL_BASE = 0,
  parameter int OUT_BASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        sp_en,
  output logic        fin,
  output logic [11:0] in_rd_addr,
  input  logic [15:0] in_rd_data,
  output logic [3:0]  wt_rd_addr,
  input  logic [15:0] wt_rd_data,
  output logic        out_wr_en,
  output logic [11:0] out_wr_addr,
  output logic [15:0] out_wr_data
);

  typedef enum logic [3:0] {
    IDLE, LOAD_W, DRAIN_W, READ_WIN, DRAIN, RESULT, WRITE, GAP, DONE
  } state_t;

  localparam logic [7:0] Q_LAST = 8'(Q_DIM - 1);
  localparam logic [7:0] Q_ROWS = 8'(Q_DIM);

  state_t             state_q, state_d;
  logic [7:0]         r_q, r_d, c_q, c_d;
  logic [3:0]         k_q, k_d, sel_q, sel_d;
  logic               pend_q, pend_d, wpend_q, wpend_d;
  logic signed [19:0] acc_q, acc_d;
  logic signed [7:0]  w_q [9];
  logic signed [7:0]  w_d [9];
  logic               fired_q, fired_d;
  logic               sp_en_q, sp_en_d, fin_q, fin_d, out_wr_en_q, out_wr_en_d;
  logic [11:0]        in_rd_addr_q, in_rd_addr_d, out_wr_addr_q, out_wr_addr_d;
  logic [3:0]         wt_rd_addr_q, wt_rd_addr_d;
  logic [15:0]        out_wr_data_q, out_wr_data_d;
  logic signed [15:0] pix16, wt16, prod;
  logic               unused_hi;

  assign unused_hi = ^{in_rd_data[15:8], wt_rd_data[15:8]};

  function automatic logic [11:0] win_addr(input logic [7:0] r, input logic [7:0] c,
                                           input logic [3:0] k);
    int row, col;
    row = ROW_BASE + int'(r) + int'(k) / 3;
    col = COL_BASE + int'(c) + int'(k) % 3;
    return 12'(row * IMG_DIM + col);
  endfunction

  function automatic logic [11:0] out_addr(input logic [7:0] r, input logic [7:0] c);
    return 12'(OUT_BASE + (ROW_BASE + int'(r)) * (IMG_DIM - 2) + COL_BASE + int'(c));
  endfunction

  function automatic logic [15:0] relu_sat(input logic signed [19:0] s);
    if (s < 20'sd0) return 16'd0;
    else if (s > 20'sd32767) return 16'h7fff;
    else return s[15:0];
  endfunction

  // A read presented on the bus is accepted only in a cycle with en=1; its data
  // is consumed the following cycle, so stalls simply hold the pending address.
  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    c_d           = c_q;
    k_d           = k_q;
    sel_d         = sel_q;
    pend_d        = 1'b0;
    wpend_d       = 1'b0;
    acc_d         = acc_q;
    w_d           = w_q;
    fired_d       = fired_q;
    sp_en_d       = 1'b0;
    fin_d         = 1'b0;
    out_wr_en_d   = 1'b0;
    in_rd_addr_d  = in_rd_addr_q;
    wt_rd_addr_d  = wt_rd_addr_q;
    out_wr_addr_d = out_wr_addr_q;
    out_wr_data_d = out_wr_data_q;
    pix16         = {{8{in_rd_data[7]}}, in_rd_data[7:0]};
    wt16          = {{8{w_q[sel_q][7]}}, w_q[sel_q]};
    prod          = pix16 * wt16;

    if (wpend_q) w_d[sel_q] = wt_rd_data[7:0];
    if (pend_q) acc_d = acc_q + {{4{prod[15]}}, prod};

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d      = LOAD_W;
          k_d          = 4'd0;
          wt_rd_addr_d = 4'd0;
        end
      end
      LOAD_W: begin
        if (en) begin
          wpend_d = 1'b1;
          sel_d   = k_q;
          if (k_q == 4'd8) begin
            state_d = DRAIN_W;
          end else begin
            k_d          = k_q + 4'd1;
            wt_rd_addr_d = k_q + 4'd1;
          end
        end
      end
      DRAIN_W: begin
        state_d      = READ_WIN;
        r_d          = 8'd0;
        c_d          = 8'd0;
        k_d          = 4'd0;
        in_rd_addr_d = win_addr(8'd0, 8'd0, 4'd0);
      end
      READ_WIN: begin
        if (en) begin
          pend_d = 1'b1;
          sel_d  = k_q;
          if (k_q == 4'd0) acc_d = '0;
          if (k_q == 4'd8) begin
            state_d = DRAIN;
          end else begin
            k_d          = k_q + 4'd1;
            in_rd_addr_d = win_addr(r_q, c_q, k_q + 4'd1);
          end
        end
      end
      DRAIN: begin
        state_d = RESULT;
        sp_en_d = 1'b1;
      end
      RESULT: begin
        state_d       = WRITE;
        out_wr_en_d   = 1'b1;
        out_wr_addr_d = out_addr(r_q, c_q);
        out_wr_data_d = relu_sat(acc_q);
      end
      WRITE: begin
        state_d = GAP;
        if (c_q == Q_LAST) begin
          c_d = 8'd0;
          r_d = r_q + 8'd1;
        end else begin
          c_d = c_q + 8'd1;
        end
      end
      GAP: begin
        if (r_q == Q_ROWS) begin
          state_d = DONE;
        end else begin
          state_d      = READ_WIN;
          k_d          = 4'd0;
          in_rd_addr_d = win_addr(r_q, c_q, 4'd0);
        end
      end
      DONE: begin
        if (en && !fired_q) begin
          fin_d   = 1'b1;
          fired_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      r_q           <= '0;
      c_q           <= '0;
      k_q           <= '0;
      sel_q         <= '0;
      pend_q        <= 1'b0;
      wpend_q       <= 1'b0;
      acc_q         <= '0;
      w_q           <= '{default: '0};
      fired_q       <= 1'b0;
      sp_en_q       <= 1'b0;
      fin_q         <= 1'b0;
      out_wr_en_q   <= 1'b0;
      in_rd_addr_q  <= '0;
      wt_rd_addr_q  <= '0;
      out_wr_addr_q <= '0;
      out_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      c_q           <= c_d;
      k_q           <= k_d;
      sel_q         <= sel_d;
      pend_q        <= pend_d;
      wpend_q       <= wpend_d;
      acc_q         <= acc_d;
      w_q           <= w_d;
      fired_q       <= fired_d;
      sp_en_q       <= sp_en_d;
      fin_q         <= fin_d;
      out_wr_en_q   <= out_wr_en_d;
      in_rd_addr_q  <= in_rd_addr_d;
      wt_rd_addr_q  <= wt_rd_addr_d;
      out_wr_addr_q <= out_wr_addr_d;
      out_wr_data_q <= out_wr_data_d;
    end
  end

  assign sp_en       = sp_en_q;
  assign fin         = fin_q;
  assign in_rd_addr  = in_rd_addr_q;
  assign wt_rd_addr  = wt_rd_addr_q;
  assign out_wr_en   = out_wr_en_q;
  assign out_wr_addr = out_wr_addr_q;
  assign out_wr_data = out_wr_data_q;

endmodule

// File: tb/tb_conv_quad_worker.sv
// tb/tb_conv_quad_worker.sv - self-checking bench for conv_quad_worker
// Runs a top-left and a bottom-right quadrant instance side by side on shared SRAM models.
module tb_conv_quad_worker;
  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        sp0, fin0, we0, sp1, fin1, we1;
  logic [11:0] ia0, ia1, oa0, oa1;
  logic [3:0]  wa0, wa1;
  logic [15:0] id0, id1, wd0, wd1, od0, od1;
  logic [15:0] in_mem [4096];
  logic [15:0] wt_mem [16];
  int          img_px [64];
  int          wt_v [9];
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct packed { logic [11:0] a; logic [15:0] d; } wr_t;
  typedef struct { int w_all; int w_ctr; int pix; int exp_d; } vec_t;

  wr_t wq0[$];
  wr_t wq1[$];
  int  n_sp0, n_sp1, n_fin0, n_fin1, fin_at0, fin_at1, sp_diff, overlap;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    id0 <= in_mem[ia0];
    id1 <= in_mem[ia1];
    wd0 <= wt_mem[wa0];
    wd1 <= wt_mem[wa1];
  end

  conv_quad_worker u_q0 (
    .clk(clk), .reset(rst_n), .en(en), .sp_en(sp0), .fin(fin0),
    .in_rd_addr(ia0), .in_rd_data(id0), .wt_rd_addr(wa0), .wt_rd_data(wd0),
    .out_wr_en(we0), .out_wr_addr(oa0), .out_wr_data(od0)
  );

  conv_quad_worker #(.IMG_DIM(8), .Q_DIM(3), .ROW_BASE(3), .COL_BASE(3), .OUT_BASE(0)) u_q3 (
    .clk(clk), .reset(rst_n), .en(en), .sp_en(sp1), .fin(fin1),
    .in_rd_addr(ia1), .in_rd_data(id1), .wt_rd_addr(wa1), .wt_rd_data(wd1),
    .out_wr_en(we1), .out_wr_addr(oa1), .out_wr_data(od1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference: direct 3x3 sum over the image, then ReLU and clamp to 32767.
  function automatic int model(input int rb, input int cb, input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += img_px[(rb + r + i) * 8 + cb + c + j] * wt_v[i * 3 + j];
    if (s < 0) return 0;
    if (s > 32767) return 32767;
    return s;
  endfunction

  task automatic load_mem();
    for (int a = 0; a < 64; a++) in_mem[a] = {8'($urandom), 8'(img_px[a])};
    for (int k = 0; k < 9; k++) wt_mem[k] = {8'($urandom), 8'(wt_v[k])};
  endtask

  task automatic run_job(input bit do_stall, input bit do_rst, input bit chk_lat);
    int dis = 0;
    int stall_left = 0;
    int tail = -1;
    int w;
    bit stalled = 0;
    bit resume_chk = 0;
    bit rst_chk = 0;
    bit ok;
    logic [11:0] ah[$];
    bit eh[$];
    wq0.delete(); wq1.delete();
    n_sp0 = 0; n_sp1 = 0; n_fin0 = 0; n_fin1 = 0;
    fin_at0 = -1; fin_at1 = -1; sp_diff = 0; overlap = 0;
    en = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 600 && tail != 0; cyc++) begin
      @(negedge clk);
      if (we0) wq0.push_back({oa0, od0});
      if (we1) wq1.push_back({oa1, od1});
      if (sp0 !== sp1) sp_diff++;
      if ((sp0 && fin0) || (sp1 && fin1)) overlap++;
      if (fin0) begin n_fin0++; if (fin_at0 < 0) fin_at0 = wq0.size(); end
      if (fin1) begin n_fin1++; if (fin_at1 < 0) fin_at1 = wq1.size(); end
      if (tail > 0) tail--;
      if (fin0 && tail < 0) tail = 5;
      if (rst_chk) begin
        check("reset_midrun_outputs_zero",
              |{sp0, fin0, we0, ia0, wa0, oa0, od0, sp1, fin1, we1, ia1, wa1, oa1, od1}, 0);
        rst_chk = 0; rst_n = 1'b1; dis = 0;
      end
      if (resume_chk) begin
        check("stall_reissue_addr", ia0, 9);
        resume_chk = 0;
      end
      if (do_stall && !stalled && ia0 == 12'd9) begin stalled = 1; stall_left = 3; end
      if (stall_left > 0) begin
        en = 1'b0; stall_left--; resume_chk = (stall_left == 0);
      end else if (dis > 0) begin
        en = 1'b0; dis--;
      end else begin
        en = 1'b1;
      end
      ah.push_back(ia0); eh.push_back(en);
      if (sp0) begin
        n_sp0++; dis = 2;
        if (chk_lat) begin
          // sp_en lands on the 11th cycle counting the window's first accepted read.
          w = n_sp0 - 1;
          ok = (ah.size() >= 11);
          for (int k = 0; k < 9; k++) begin
            int idx;
            idx = ah.size() - 11 + k;
            if (ok) ok = eh[idx] && (ah[idx] == 12'((w / 3 + k / 3) * 8 + w % 3 + k % 3));
          end
          check($sformatf("sp_latency_win%0d", w), ok, 1);
        end
        if (do_rst && n_sp0 == 4) begin rst_n = 1'b0; rst_chk = 1; end
      end
      if (sp1) n_sp1++;
    end
  endtask

  task automatic cmp_writes(input string tag, input wr_t q[$], input int rb, input int cb,
                            input int n_pre, input int exp_d);
    check({tag, "_write_count"}, q.size(), n_pre + 9);
    for (int n = 0; n < 9; n++) begin
      if (n_pre + n < q.size()) begin
        check($sformatf("%s_addr%0d", tag, n), q[n_pre + n].a, (rb + n / 3) * 6 + cb + n % 3);
        check($sformatf("%s_data%0d", tag, n), q[n_pre + n].d, model(rb, cb, n / 3, n % 3));
        if (exp_d >= 0) check($sformatf("%s_tbl%0d", tag, n), q[n_pre + n].d, exp_d);
      end
    end
  endtask

  task automatic job_checks(input string tag, input int n_pre, input int exp_sp, input int exp_d);
    check({tag, "_sp_count"}, n_sp0, exp_sp);
    check({tag, "_fin_count"}, n_fin0, 1);
    check({tag, "_fin_after_last_write"}, fin_at0, n_pre + 9);
    check({tag, "_q3_fin_count"}, n_fin1, 1);
    check({tag, "_q3_sp_align"}, sp_diff, 0);
    check({tag, "_sp_fin_overlap"}, overlap, 0);
    cmp_writes({tag, "_q0"}, wq0, 0, 0, n_pre, exp_d);
    cmp_writes({tag, "_q3"}, wq1, 3, 3, n_pre, exp_d);
  endtask

  task automatic rand_data();
    for (int a = 0; a < 64; a++) img_px[a] = int'($urandom_range(255)) - 128;
    for (int k = 0; k < 9; k++) wt_v[k] = int'($urandom_range(255)) - 128;
  endtask

  initial begin
    vec_t tbl [7];
    int   d21;
    tbl[0] = '{1, 1, 1, 9};
    tbl[1] = '{0, -1, 5, 0};
    tbl[2] = '{127, 127, 127, 32767};
    tbl[3] = '{-128, -128, 127, 0};
    tbl[4] = '{0, 100, 100, 10000};
    tbl[5] = '{-1, -1, -100, 900};
    tbl[6] = '{2, -7, 50, 450};
    for (int a = 0; a < 4096; a++) in_mem[a] = '0;
    for (int k = 0; k < 16; k++) wt_mem[k] = '0;
    en = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sp_en", sp0, 0);
    check("rst_fin", fin0, 0);
    check("rst_in_rd_addr", ia0, 0);
    check("rst_wt_rd_addr", wa0, 0);
    check("rst_out_wr_en", we0, 0);
    check("rst_out_wr_addr", oa0, 0);
    check("rst_out_wr_data", od0, 0);

    for (int t = 0; t < 7; t++) begin
      for (int a = 0; a < 64; a++) img_px[a] = tbl[t].pix;
      for (int k = 0; k < 9; k++) wt_v[k] = (k == 4) ? tbl[t].w_ctr : tbl[t].w_all;
      load_mem();
      run_job(1'b0, 1'b0, 1'b1);
      job_checks($sformatf("vec%0d", t), 0, 9, tbl[t].exp_d);
    end

    rand_data(); load_mem();
    run_job(1'b1, 1'b0, 1'b0);
    job_checks("stall", 0, 9, -1);

    for (int a = 0; a < 64; a++) img_px[a] = a % 128;
    for (int k = 0; k < 9; k++) wt_v[k] = (k == 4) ? 1 : 0;
    load_mem();
    run_job(1'b0, 1'b0, 1'b1);
    job_checks("ramp", 0, 9, -1);
    d21 = -1;
    foreach (wq1[i]) if (wq1[i].a == 12'd21) d21 = int'(wq1[i].d);
    check("ramp_q3_addr21_data", d21, 36);

    rand_data(); load_mem();
    run_job(1'b0, 1'b1, 1'b0);
    job_checks("reset", 3, 13, -1);
    check("reset_restart_addr0", (wq0.size() > 3) ? wq0[3].a : 12'hfff, 0);

    for (int n = 0; n < 3; n++) begin
      rand_data(); load_mem();
      run_job(1'b0, 1'b0, 1'b1);
      job_checks($sformatf("rand%0d", n), 0, 9, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
